// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Computes a - b modulo 2^WIDTH one bit per clock, LSB first. A start
//   request loads both operands. WIDTH clocks later the result is
//   published, and done pulses for one cycle.
//
//   Optional feature macro: SUB_FLAGS_EN. When it is defined, the block adds
//   the zero, negative and overflow result flags.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   start      : begin a subtraction (sampled in IDLE or DONE only)
//   a, b       : minuend / subtrahend, captured on the accepting edge
//   busy       : high while bits are being processed
//   done       : one-cycle pulse when diff/borrow_out are refreshed
//   diff       : a - b modulo 2^WIDTH, held until the next result
//   borrow_out : final borrow, 1 iff a < b (unsigned)
//   zero, negative, overflow : result flags (SUB_FLAGS_EN only)
module serial_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             negative,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_res;     // result bits gathered so far, MSB-aligned
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
`ifdef SUB_FLAGS_EN
  logic             r_a_msb;   // operand signs kept for overflow detection
  logic             r_b_msb;
`endif

  logic [1:0]       w_fs;
  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_nxt;

  // One-bit full subtractor. Returns {borrow_out, difference}.
  function automatic logic [1:0] fs_bit(input logic x, input logic y,
                                        input logic bin);
    logic d;
    logic bo;
    d  = x ^ y ^ bin;
    bo = (~x & y) | (~(x ^ y) & bin);
    return {bo, d};
  endfunction

  assign w_fs      = fs_bit(r_a[0], r_b[0], r_borrow);
  assign w_d       = w_fs[0];
  assign w_bout    = w_fs[1];
  // New difference bit enters at the MSB end. After WIDTH bits, bit 0 of the
  // result has shifted all the way down to the LSB.
  assign w_res_nxt = {w_d, r_res};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      r_cnt      <= '0;
      r_borrow   <= 1'b0;
`ifdef SUB_FLAGS_EN
      zero       <= 1'b0;
      negative   <= 1'b0;
      overflow   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
`ifdef SUB_FLAGS_EN
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
`endif
            busy     <= 1'b1;
            r_state  <= RUN;
          end else begin
            busy     <= 1'b0;
            r_state  <= IDLE;
          end
        end
        RUN: begin
          r_a      <= {1'b0, r_a[WIDTH-1:1]};
          r_b      <= {1'b0, r_b[WIDTH-1:1]};
          r_res    <= w_res_nxt[WIDTH-1:1];
          r_borrow <= w_bout;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST_BIT) begin
            // Outputs change only here, so no partial result is ever visible.
            diff       <= w_res_nxt;
            borrow_out <= w_bout;
`ifdef SUB_FLAGS_EN
            zero       <= (w_res_nxt == '0);
            negative   <= w_d;
            overflow   <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
`endif
            busy       <= 1'b0;
            done       <= 1'b1;
            r_state    <= DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SUB_FLAGS_EN
  logic         zero;
  logic         negative;
  logic         overflow;
`endif

  int total = 0;
  int bad   = 0;

  // Expected published result (what diff/borrow_out must currently hold).
  logic [W-1:0] exp_diff = '0;
  logic         exp_borrow = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SUB_FLAGS_EN
    ,
    .zero       (zero),
    .negative   (negative),
    .overflow   (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags();
`ifdef SUB_FLAGS_EN
    chk("zero", {63'd0, zero}, {63'd0, exp_diff == 0});
    chk("negative", {63'd0, negative}, {63'd0, exp_diff[W-1]});
`endif
  endtask

  // Launch a - b, optionally pulse start with junk operands while in RUN at
  // cycle index glitch, and return once done is observed (in the DONE cycle).
  task automatic run(input logic [W-1:0] ia, input logic [W-1:0] ib,
                     input int glitch);
    int n;
    int nb;
    int sa;
    int sb;
    int r;
    logic [W-1:0] prev;
    prev  = exp_diff;
    a     = ia;
    b     = ib;
    start = 1'b1;
    step();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    n  = 0;
    nb = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) nb++;
      chk("hold_while_busy", {56'd0, diff}, {56'd0, prev});
      if (n == glitch) begin
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'h00;
      end else begin
        start = 1'b0;
      end
      step();
      n++;
    end
    start = 1'b0;
    // Reference: plain modular arithmetic on the captured operands.
    exp_diff   = ia - ib;
    exp_borrow = (ia < ib);
    chk("latency", 64'(n), 64'(W));
    chk("busy_cycles", 64'(nb), 64'(W));
    chk("busy_in_done", {63'd0, busy}, 64'd0);
    chk("diff", {56'd0, diff}, {56'd0, exp_diff});
    chk("borrow_out", {63'd0, borrow_out}, {63'd0, exp_borrow});
    chk_flags();
`ifdef SUB_FLAGS_EN
    sa = int'($signed(ia));
    sb = int'($signed(ib));
    r  = sa - sb;
    chk("overflow", {63'd0, overflow}, {63'd0, (r > 127) || (r < -128)});
`endif
  endtask

  // After a done cycle with start low: done must drop, outputs must hold.
  task automatic after_done();
    step();
    chk("done_pulse_len", {63'd0, done}, 64'd0);
    chk("idle_busy", {63'd0, busy}, 64'd0);
    chk("diff_hold", {56'd0, diff}, {56'd0, exp_diff});
  endtask

  initial begin
    int seen;
    // Reset, with start asserted at the same time (must be ignored).
    rst = 1'b1; start = 1'b1; a = 8'h05; b = 8'h03;
    step();
    step();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_diff", {56'd0, diff}, 64'd0);
    chk("rst_borrow", {63'd0, borrow_out}, 64'd0);
    chk_flags();
    rst = 1'b0; start = 1'b0;
    step();
    chk("post_rst_idle", {63'd0, busy}, 64'd0);

    // Directed cases.
    run(8'h05, 8'h03, -1); after_done();
    run(8'h03, 8'h05, -1); after_done();
    run(8'h80, 8'h01, -1); after_done();
    run(8'h2A, 8'h2A, -1); after_done();

    // start during RUN is ignored; exactly one done follows.
    run(8'h10, 8'h01, 3);
    chk("glitch_diff", {56'd0, diff}, 64'h0F);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done === 1'b1) seen++;
    end
    chk("glitch_one_done", 64'(seen), 64'd0);

    // Back-to-back: start high in DONE re-accepts; second done 9 cycles on.
    run(8'h33, 8'h11, -1);
    run(8'h09, 8'h04, -1);
    chk("b2b_diff", {56'd0, diff}, 64'h05);
    after_done();

    // Reset 4 cycles into RUN aborts with no done pulse.
    a = 8'h44; b = 8'h11; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("abort_was_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_diff = '0; exp_borrow = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_diff", {56'd0, diff}, 64'd0);
    chk("abort_borrow", {63'd0, borrow_out}, 64'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done === 1'b1) seen++;
    end
    chk("abort_no_done", 64'(seen), 64'd0);

    // Randomized operands, gaps and back-to-back chaining.
    run(8'hFF, 8'h00, -1); after_done();
    run(8'h00, 8'hFF, -1); after_done();
    for (int k = 0; k < 30; k++) begin
      run(W'($urandom), W'($urandom), int'($urandom_range(0, 12)) - 4);
      if ($urandom_range(0, 2) != 0) begin
        after_done();
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
      end
    end
    after_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal range 2..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin a subtraction; sampled only in IDLE or DONE.
REQ-005 SHALL have port a  input  WIDTH  minuend, captured on the accepting edge.
REQ-006 SHALL have port b  input  WIDTH  subtrahend, captured on the accepting edge.
REQ-007 SHALL have port busy  output  1  high while state is RUN.
REQ-008 SHALL have port done  output  1  one-cycle pulse, high while state is DONE.
REQ-009 SHALL have port diff  output  WIDTH  result a - b modulo 2^WIDTH.
REQ-010 SHALL have port borrow_out  output  1  final borrow; 1 iff a < b unsigned.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 IDLE: start=1 -> latch a, b into shift registers, clear borrow flop, clear bit counter, go to RUN; else stay.
REQ-013 RUN: each cycle SHALL process one bit, LSB first: d = a0 ^ b0 ^ borrow; borrow' = (~a0 & b0) | (~(a0 ^ b0) & borrow).
REQ-014 RUN: d SHALL be shifted into the result register at the MSB end; operand registers shift right by one.
REQ-015 RUN SHALL last exactly WIDTH cycles (counter 0..WIDTH-1); on the edge processing bit WIDTH-1 go to DONE.
REQ-016 Latency: start accepted at edge N -> done=1 in the cycle following edge N+WIDTH, with diff/borrow_out valid in that cycle.
REQ-017 DONE lasts one cycle; start=1 in DONE -> accept new operands, go to RUN (back-to-back); else go to IDLE.
REQ-018 start SHALL be ignored while in RUN; operands not re-latched, result unaffected.
REQ-019 diff and borrow_out SHALL be updated only on the transition into DONE and SHALL hold until the next transition into DONE or reset.
REQ-020 diff and borrow_out SHALL NOT show partial results while busy=1.
REQ-021 a and b SHALL be don't-care except on the accepting edge.

Reset
REQ-022 rst=1 on a rising edge SHALL force state IDLE, busy=0, done=0, diff=0, borrow_out=0, counter=0, borrow flop=0.
REQ-023 rst SHALL take priority over start and SHALL abort any RUN in progress with no done pulse.
REQ-024 start asserted in the same cycle as rst SHALL be ignored.

Configuration
REQ-025 Macro SUB_FLAGS_EN SHALL, when defined, add outputs zero, negative, overflow (each 1 bit).
REQ-026 With SUB_FLAGS_EN: zero = (diff == 0); negative = diff[WIDTH-1]; overflow = signed overflow (a, b signs differ and diff sign differs from a); all registered with diff, reset to 0.
REQ-027 Without SUB_FLAGS_EN: ports and flag logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=8)
REQ-028 a=0x05, b=0x03, start 1 cycle -> busy for 8 cycles, done pulse 1 cycle, diff=0x02, borrow_out=0.
REQ-029 a=0x03, b=0x05 -> diff=0xFE, borrow_out=1; with SUB_FLAGS_EN negative=1, zero=0, overflow=0.
REQ-030 a=0x80, b=0x01 -> diff=0x7F, borrow_out=0; with SUB_FLAGS_EN overflow=1; then a=0x2A, b=0x2A -> diff=0x00, zero=1.
REQ-031 start pulsed with a=0xFF, b=0x00 during RUN of 0x10-0x01 -> ignored; result diff=0x0F, exactly one done.
REQ-032 start held high through DONE with a=0x09, b=0x04 -> re-accepted, second done exactly 9 cycles after first, diff=0x05.
REQ-033 rst asserted 4 cycles into RUN -> next cycle busy=0, done=0, diff=0, borrow_out=0; no done pulse follows.
